// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle controller.
// Holds the FSM state enum, opcode constants, ALU/immediate/select codes,
// the ALU operation class enum and an opcode-to-immediate-type helper.
package rv32i_ctrl_pkg;

    localparam bit RESET_TO_FETCH         = 1'b1;
    localparam bit ILLEGAL_STICKY_DEFAULT = 1'b1;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned ALUC_W = 3;
    localparam int unsigned IMM_W  = 3;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_JAL,
        S_BEQ,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_FUNCT
    } alu_op_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;
    localparam logic [ALUC_W-1:0] ALU_INV = 3'b111;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [IMM_W-1:0] imm_type_of(input logic [OP_W-1:0] op);
        logic [IMM_W-1:0] t;
        t = IMM_I;
        case (op)
            OP_SW:   t = IMM_S;
            OP_BEQ:  t = IMM_B;
            OP_JAL:  t = IMM_J;
            default: t = IMM_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode.
// Ports: i alu_op (ADD/SUB/FUNCT class), func3, func7_5 (funct7 bit 5),
//        op_5 (opcode bit 5, set for R-type); o alu_control (ALU code).
module alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  alu_op_t           alu_op,
    input  logic [F3_W-1:0]   func3,
    input  logic              func7_5,
    input  logic              op_5,
    output logic [ALUC_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (func3)
                    // funct7[5] only selects SUB for register-register ops
                    3'b000:  alu_control = (op_5 && func7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_INV;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the RV32I multicycle datapath (lw, sw, R/I ALU, beq, jal).
// Inputs: clk, rst (async, active high), op_code/func3/func7 from IR, zero
//         flag from ALU, mem_ready handshake from memory.
// Outputs: memory strobes (mem_req, mem_write, adr_src), register enables
//          (ir_write, pc_write, reg_write), datapath selects (alu_src_a,
//          alu_src_b, result_src, imm_type, alu_control) and illegal.
// Outputs are combinational: the fetch/branch enables depend on mem_ready
// and zero in the same cycle, and reset must drop strobes immediately.
module multicycle_control
    import rv32i_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_STICKY = ILLEGAL_STICKY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op_code,
    input  logic [F3_W-1:0]   func3,
    input  logic [F7_W-1:0]   func7,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_write,
    output logic              adr_src,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic [SEL_W-1:0]  alu_src_a,
    output logic [SEL_W-1:0]  alu_src_b,
    output logic [SEL_W-1:0]  result_src,
    output logic [IMM_W-1:0]  imm_type,
    output logic [ALUC_W-1:0] alu_control,
    output logic              illegal
);

    state_t  r_state;
    state_t  w_next_state;
    alu_op_t w_alu_op;
    logic    w_unused;

    // Only funct7[5] matters for the supported instruction set.
    assign w_unused = ^{func7[6], func7[4:0]};

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .func3       (func3),
        .func7_5     (func7[5]),
        .op_5        (op_code[5]),
        .alu_control (alu_control)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:     if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (op_code)
                    OP_LW, OP_SW: w_next_state = S_MEM_ADR;
                    OP_R:         w_next_state = S_EXEC_R;
                    OP_I:         w_next_state = S_EXEC_I;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_TRAP;
                endcase
            end
            S_MEM_ADR:   w_next_state = (op_code == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXEC_R:    w_next_state = S_ALU_WB;
            S_EXEC_I:    w_next_state = S_ALU_WB;
            S_ALU_WB:    w_next_state = S_FETCH;
            S_JAL:       w_next_state = S_ALU_WB;
            S_BEQ:       w_next_state = S_FETCH;
            S_TRAP:      w_next_state = ILLEGAL_STICKY ? S_TRAP : S_FETCH;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        w_alu_op   = ALU_OP_ADD;
        imm_type   = imm_type_of(op_code);

        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // PC-relative target lands in ALUOut for beq/jal
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEM_WB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                w_alu_op  = ALU_OP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                w_alu_op   = ALU_OP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase

        // Reset kills every strobe at once, even mid-access
        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule
